mux_sel_arbiter: RTL
====================

# mux_sel_arbiter

- Clocked round-robin arbiter that owns the select input of the shared N-bit 2:1 / 4:1 mux interface.
- Up to 2**S requesters compete for the mux; one winner at a time gets `o_sel`, and its data is forwarded downstream under a valid/ready handshake.
- Each grant lasts for a bounded burst of beats, then arbitration runs again.
- Sits between the requesting sources and the mux instance; `o_sel` connects directly to the mux `i_sel`.

## Interface
- `S`, default 1 — select width; 1 gives 2 requesters, 2 gives 4. Other values are an elaboration `$error`.
- `MAX_BURST`, default 4 — maximum beats per grant; must be ≥1.
- `i_clk`  input  1 — single clock; all state updates on the rising edge.
- `i_rst_n`  input  1 — asynchronous, active-low reset.
- `i_req`  input  2**S — per-requester request, level-sensitive.
- `i_ready`  input  1 — downstream accepts the current beat.
- `o_gnt`  output  2**S — one-hot grant, registered.
- `o_sel`  output  S — binary index of the granted requester, registered; drives mux `i_sel`.
- `o_valid`  output  1 — mux output holds a valid beat for the granted requester.

## Operation
- States: `IDLE`, `GRANT`.
- Arbitration:
  - Round-robin pointer `last` holds the index of the previous winner.
  - Search order is `last+1` … `last`, modulo 2**S.
  - The first requester found with `i_req` high wins.
- IDLE→GRANT: any `i_req` high. The winner is registered into `o_gnt`/`o_sel`, `last` takes the winner index, and the beat counter `cnt` clears to 0.
- In GRANT:
  - `o_valid` = `i_req[o_sel]`.
  - A beat transfers when `o_valid && i_ready`; on transfer, `cnt` increments.
- The burst ends at the edge where either of these holds:
  - a transfer occurs with `cnt == MAX_BURST-1`;
  - `i_req[o_sel]` is low (requester withdrew; no beat is counted).
- At burst end, re-arbitrate in the same cycle from the current `i_req`:
  - Any requester high → stay in GRANT with the new winner and `cnt` = 0, with no bubble.
  - No requester high → IDLE, `o_gnt` = 0, `o_sel` holds its last value.
- Sole requester still high at burst end: the wrap-around search re-grants it, and `cnt` restarts.
- While in GRANT, new requests from other requesters have no effect until burst end.
- `cnt` width is `$clog2(MAX_BURST+1)`; it never exceeds `MAX_BURST-1`.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, `o_gnt` = 0, `o_sel` = 0, `o_valid` = 0, `cnt` = 0.
  - `last` = 2**S-1, so requester 0 has first priority out of reset.
- Grant latency: `i_req` rising in cycle t (sampled at edge t+1) → `o_gnt`/`o_sel` valid after edge t+1. `o_valid` is high from that cycle if the request is still held.
- `o_sel` and `o_gnt` change only at rising clock edges. A mux sampling on the same clock sees a stable select for the whole cycle.
- Reset asserted mid-burst: all outputs return to reset values immediately. After reset release, the first arbitration is at the first rising edge.
- `i_ready` low stalls the burst indefinitely: `cnt` holds and the grant is kept.

## Configuration
- `MUX_ARB_ASSERT_EN` defined — the module compiles these concurrent assertions, clocked on `i_clk` and disabled when `i_rst_n` is low:
  - `$onehot0(o_gnt)`;
  - `o_gnt != 0` implies `o_gnt[o_sel]`;
  - `o_valid` implies `o_gnt != 0`;
  - `cnt < MAX_BURST`;
  - a requester held high is granted within 2**S × `MAX_BURST` cycles while `i_ready` stays high (starvation check).
- `MUX_ARB_ASSERT_EN` not defined — no assertion code is compiled; RTL behaviour is identical.

## Structure
- Package `mux_arb_pkg`:
  - shared `MUX_CONFIG_S` / `MUX_CONFIG_N` defaults;
  - `arb_state_e` enum (`IDLE`, `GRANT`).
- Sub-module `rr_pick`: purely combinational. Inputs are `req` and `last`; outputs are `winner` index, `winner_onehot` and `any`. It is reused for both IDLE and burst-end arbitration.
- The top module holds the FSM, `cnt`, `last` and the output registers.

## Test plan
- Reset, `S`=2, `i_req`=4'b1111, `i_ready`=1 held:
  - grants go 0,1,2,3,0…;
  - each grant has 4 `o_valid` beats;
  - grants switch back-to-back with no idle cycle.
- `S`=1, only `i_req[1]` high for 10 cycles, `i_ready`=1:
  - `o_sel`=1 for the whole window;
  - re-grant at every 4th beat;
  - `o_valid` stays high continuously.
- Requester 2 granted, drops `i_req[2]` after 2 beats, `i_req[3]` high → next edge `o_gnt`=4'b1000, `cnt`=0.
- `i_ready`=0 for 5 cycles mid-burst → `cnt`, `o_sel` and `o_gnt` unchanged; the burst completes after `i_ready` returns.
- `i_rst_n` pulsed low during beat 2 of a burst:
  - `o_gnt`/`o_valid` go to 0 without waiting for a clock edge;
  - the first grant after release goes to the lowest-indexed active requester.
- With `MUX_ARB_ASSERT_EN`, a forced two-hot `o_gnt` triggers an assertion failure.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// rtl/mux_sel_arbiter_pkg.sv - shared defaults and state type for the mux select arbiter
// Package mux_arb_pkg:
//   MUX_CONFIG_S / MUX_CONFIG_N : default select width and requester count
//   arb_state_e                 : arbiter FSM states (IDLE, GRANT)
package mux_arb_pkg;

    localparam int MUX_CONFIG_S = 1;
    localparam int MUX_CONFIG_N = 1 << MUX_CONFIG_S;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - request/grant/handshake bundle between sources, arbiter and mux
// Signals:
//   i_req   [2**S-1:0] : per-requester level request (sources -> arbiter)
//   i_ready            : downstream accepts the current beat
//   o_gnt   [2**S-1:0] : one-hot registered grant
//   o_sel   [S-1:0]    : registered binary select, drives mux i_sel
//   o_valid            : mux output carries a valid beat
// Modports: master = arbiter side, slave = sources/downstream side.
interface mux_sel_arbiter_if import mux_arb_pkg::*; #(
    parameter int S = MUX_CONFIG_S
) ();
    localparam int N = 1 << S;

    logic [N-1:0] i_req;
    logic         i_ready;
    logic [N-1:0] o_gnt;
    logic [S-1:0] o_sel;
    logic         o_valid;

    modport master (
        input  i_req,
        input  i_ready,
        output o_gnt,
        output o_sel,
        output o_valid
    );

    modport slave (
        output i_req,
        output i_ready,
        input  o_gnt,
        input  o_sel,
        input  o_valid
    );
endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rtl/mux_sel_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports:
//   req           [2**S-1:0] : current requests
//   last          [S-1:0]    : previous winner; search starts at last+1 and wraps to last
//   winner        [S-1:0]    : index of first requester found (0 when none)
//   winner_onehot [2**S-1:0] : one-hot of winner, zero when none
//   any                      : at least one request is high
module rr_pick #(
    parameter int S = 1
) (
    input  logic [(1<<S)-1:0] req,
    input  logic [S-1:0]      last,
    output logic [S-1:0]      winner,
    output logic [(1<<S)-1:0] winner_onehot,
    output logic              any
);
    localparam int N = 1 << S;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin : g_search
            logic [S-1:0] idx;
            // S-bit addition wraps modulo N; k == N lands back on last itself
            idx = last + S'(k);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

    assign winner_onehot = any ? (N'(1) << winner) : '0;

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin arbiter owning the select of a shared 2:1/4:1 mux
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mux_sel_arbiter_if.master (i_req, i_ready in; o_gnt, o_sel, o_valid out)
// Parameters: S (1 or 2), MAX_BURST (>=1 beats per grant).
// Optional: MUX_ARB_ASSERT_EN compiles protocol and starvation assertions.
module mux_sel_arbiter import mux_arb_pkg::*; #(
    parameter int S         = MUX_CONFIG_S,
    parameter int MAX_BURST = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mux_sel_arbiter_if.master  bus
);
    localparam int N  = 1 << S;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    if (S != 1 && S != 2) begin : g_bad_s
        $error("mux_sel_arbiter: S must be 1 or 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("mux_sel_arbiter: MAX_BURST must be >= 1");
    end

    arb_state_e    state_q, state_nxt;
    logic [N-1:0]  gnt_q, gnt_nxt;
    logic [S-1:0]  sel_q, sel_nxt;
    logic [S-1:0]  last_q, last_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    logic [S-1:0]  pick_winner;
    logic [N-1:0]  pick_onehot;
    logic          pick_any;

    rr_pick #(.S(S)) u_pick (
        .req           (bus.i_req),
        .last          (last_q),
        .winner        (pick_winner),
        .winner_onehot (pick_onehot),
        .any           (pick_any)
    );

    logic req_cur, xfer, burst_end, rearb;

    assign req_cur   = bus.i_req[sel_q];
    assign xfer      = (state_q == GRANT) && req_cur && bus.i_ready;
    // A withdrawn requester ends its burst without a counted beat
    assign burst_end = (state_q == GRANT) && (!req_cur || (xfer && cnt_q == CNT_LAST));
    assign rearb     = (state_q == IDLE) || burst_end;

    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        if (rearb) begin
            if (pick_any) begin
                state_nxt = GRANT;
                gnt_nxt   = pick_onehot;
                sel_nxt   = pick_winner;
                last_nxt  = pick_winner;
                cnt_nxt   = '0;
            end else begin
                // o_sel deliberately keeps the previous winner while idle
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        end else if (xfer) begin
            cnt_nxt = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= '1;  // requester 0 searched first out of reset
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
            sel_q   <= sel_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.o_gnt   = gnt_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_valid = (state_q == GRANT) && req_cur;

`ifdef MUX_ARB_ASSERT_EN
    a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(bus.o_gnt));
    a_gnt_sel: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.o_gnt != '0) |-> bus.o_gnt[bus.o_sel]);
    a_valid_gnt: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.o_valid |-> (bus.o_gnt != '0));
    a_cnt_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        cnt_q < CW'(MAX_BURST));

    // Cycles each requester has waited ungranted with downstream ready
    int unsigned wait_cnt [N];
    for (genvar i = 0; i < N; i++) begin : g_starve
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                wait_cnt[i] <= 0;
            end else if (bus.i_req[i] && !bus.o_gnt[i] && bus.i_ready) begin
                if (wait_cnt[i] <= N * MAX_BURST) begin
                    wait_cnt[i] <= wait_cnt[i] + 1;
                end
            end else begin
                wait_cnt[i] <= 0;
            end
        end
        a_starve: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            wait_cnt[i] <= N * MAX_BURST);
    end
`endif

endmodule
